// File: rtl/dac_seq_ctrl.sv
// rtl/dac_seq_ctrl.sv - round-robin dirty-channel write sequencer for a parallel-input DAC
// Optional feature macro: DAC_SAT_EN (saturating inc/dec instead of modulo wrap)
module dac_seq_ctrl #(
    parameter int DW      = 8,
    parameter int NCH     = 2,
    parameter int CW      = 1,
    parameter int T_SETUP = 200,
    parameter int T_WR    = 50,
    parameter int T_HOLD  = 30,
    parameter int CNTW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] ch_sel,
    input  logic          inc,
    input  logic          dec,
    input  logic [DW-1:0] step,
    output logic          busy,
    output logic          wr_done,
    output logic          dac_csn,
    output logic          dac_wrn,
    output logic          dac_ldacn,
    output logic [CW-1:0] dac_addr,
    output logic [DW-1:0] dac_d,
    output logic [DW-1:0] led_out
);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [CW-1:0]   ptr, ptr_n;
    logic [DW-1:0]   value [NCH];
    logic [NCH-1:0]  dirty, dirty_n;

    logic            hi_found, lo_found, any_dirty, start;
    logic [CW-1:0]   hi_idx, lo_idx, sel, addr_n;
    logic [DW-1:0]   sel_val, d_n;
    logic            csn_n, wrn_n, wr_done_n;

    logic            hit, edit, mark;
    logic [DW-1:0]   cur, nv;
`ifdef DAC_SAT_EN
    logic [DW:0]     sum;
`endif

    // Next dirty channel: lowest dirty index above ptr, otherwise lowest at or below ptr (wrap)
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (dirty[j]) begin
                if (j > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = CW'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = CW'(j);
                end
            end
        end
        any_dirty = hi_found | lo_found;
        sel       = hi_found ? hi_idx : lo_idx;
        sel_val   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (sel == CW'(j)) sel_val = value[j];
        end
    end

    // Edit arithmetic for the selected channel; out-of-range ch_sel never hits
    always_comb begin
        hit = 1'b0;
        cur = '0;
        for (int j = 0; j < NCH; j++) begin
            if (ch_sel == CW'(j)) begin
                hit = 1'b1;
                cur = value[j];
            end
        end
        edit = hit & (inc ^ dec);
`ifdef DAC_SAT_EN
        sum = {1'b0, cur} + {1'b0, step};
        if (inc) nv = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
        else     nv = (step > cur) ? '0 : cur - step;
        mark = (nv != cur) || (step == '0);
`else
        nv   = inc ? cur + step : cur - step;
        mark = 1'b1;
`endif
    end

    // Dirty bits: an edit re-marks the channel even if it is being picked this cycle
    always_comb begin
        dirty_n = dirty;
        for (int j = 0; j < NCH; j++) begin
            if (start && sel == CW'(j)) dirty_n[j] = 1'b0;
            if (edit && mark && ch_sel == CW'(j)) dirty_n[j] = 1'b1;
        end
    end

    // Value registers, dirty bits and LED mirror
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NCH; j++) value[j] <= '0;
            dirty   <= '1;
            led_out <= '0;
        end else begin
            for (int j = 0; j < NCH; j++) begin
                if (edit && ch_sel == CW'(j)) value[j] <= nv;
            end
            dirty   <= dirty_n;
            led_out <= hit ? cur : '0;
        end
    end

    // FSM next state and next values of the registered DAC pins
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        ptr_n   = ptr;
        csn_n   = dac_csn;
        wrn_n   = dac_wrn;
        addr_n  = dac_addr;
        d_n     = dac_d;
        start   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                csn_n = 1'b1;
                wrn_n = 1'b1;
                start = any_dirty;
            end
            SETUP: begin
                if (cnt == CNTW'(T_SETUP - 1)) begin
                    state_n = WRITE;
                    cnt_n   = '0;
                    wrn_n   = 1'b0;
                end
            end
            WRITE: begin
                if (cnt == CNTW'(T_WR - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    wrn_n   = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CNTW'(T_HOLD - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    csn_n   = 1'b1;
                    start   = any_dirty;
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = SETUP;
            cnt_n   = '0;
            csn_n   = 1'b0;
            wrn_n   = 1'b1;
            addr_n  = sel;
            d_n     = sel_val;
            ptr_n   = sel;
        end
        wr_done_n = (state_n == HOLD) && (cnt_n == CNTW'(T_HOLD - 1));
    end

    // State register and registered DAC pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= CW'(NCH - 1);
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            dac_csn   <= 1'b1;
            dac_wrn   <= 1'b1;
            dac_ldacn <= 1'b1;
            dac_addr  <= '0;
            dac_d     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            busy      <= (state_n != IDLE);
            wr_done   <= wr_done_n;
            dac_csn   <= csn_n;
            dac_wrn   <= wrn_n;
            dac_ldacn <= 1'b0;
            dac_addr  <= addr_n;
            dac_d     <= d_n;
        end
    end

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// tb/tb_dac_seq_ctrl.sv - self-checking bench for dac_seq_ctrl
module tb_dac_seq_ctrl;
    localparam int DW = 8, NCH = 2, CW = 2, TS = 4, TW = 2, TH = 3, CNTW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] ch_sel = '0;
    logic          inc = 1'b0, dec = 1'b0;
    logic [DW-1:0] step = '0;
    logic          busy, wr_done, dac_csn, dac_wrn, dac_ldacn;
    logic [CW-1:0] dac_addr;
    logic [DW-1:0] dac_d, led_out;

    dac_seq_ctrl #(.DW(DW), .NCH(NCH), .CW(CW), .T_SETUP(TS), .T_WR(TW), .T_HOLD(TH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .ch_sel(ch_sel), .inc(inc), .dec(dec), .step(step),
        .busy(busy), .wr_done(wr_done), .dac_csn(dac_csn), .dac_wrn(dac_wrn), .dac_ldacn(dac_ldacn),
        .dac_addr(dac_addr), .dac_d(dac_d), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Completed DAC writes as seen on the pins
    typedef struct {int addr; int d; bit stable; int fall; int done;} wr_t;
    wr_t wq[$];

    bit   in_wr = 0, c_stable = 0;
    int   c_addr = 0, c_d = 0, c_fall = 0;
    logic prev_wrn = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            in_wr    = 0;
            prev_wrn = 1'b1;
        end else begin
            if (prev_wrn === 1'b1 && dac_wrn === 1'b0) begin
                in_wr    = 1;
                c_addr   = int'(dac_addr);
                c_d      = int'(dac_d);
                c_fall   = cyc;
                c_stable = (dac_csn === 1'b0);
            end else if (in_wr && (int'(dac_addr) != c_addr || int'(dac_d) != c_d || dac_csn !== 1'b0)) begin
                c_stable = 0;
            end
            if (wr_done === 1'b1) begin
                wq.push_back('{c_addr, c_d, c_stable && in_wr, c_fall, cyc});
                in_wr = 0;
            end
            prev_wrn = dac_wrn;
        end
    end

    // Reference: a channel value after one edit, from the arithmetic rules
    int mv [NCH];
    function automatic int apply(input int v, input bit up, input int s);
`ifdef DAC_SAT_EN
        if (up) return (v + s > 255) ? 255 : v + s;
        return (v - s < 0) ? 0 : v - s;
`else
        return up ? ((v + s) & 255) : ((v - s) & 255);
`endif
    endfunction

    task automatic pulse(input int ch, input bit i, input bit d, input int s, output int n);
        @(posedge clk); #1;
        ch_sel = CW'(ch); inc = i; dec = d; step = DW'(s); n = cyc;
        @(posedge clk); #1;
        inc = 1'b0; dec = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int b = 0;
        while (quiet < 4 && b < 3000) begin
            @(negedge clk);
            b++;
            if (busy === 1'b0) quiet++; else quiet = 0;
        end
        check({tag, " idle"}, int'(quiet >= 4), 1);
    endtask

    task automatic wait_wrn_low(input string tag);
        int b = 0;
        while (dac_wrn !== 1'b0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check({tag, " wrn_low"}, int'(dac_wrn === 1'b0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ch, gap;
        int lastw [NCH];
        bit i, d;
        int s;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst wr_done", wr_done, 0);
        check("rst csn", dac_csn, 1);
        check("rst wrn", dac_wrn, 1);
        check("rst ldacn", dac_ldacn, 1);
        check("rst addr", dac_addr, 0);
        check("rst d", dac_d, 0);
        check("rst led", led_out, 0);
        mv[0] = 0; mv[1] = 0;
        wq.delete();
        @(posedge clk); #1 rst = 1'b0;

        // Init sequence writes both channels with 0
        wait_idle("init");
        check("init writes", wq.size(), 2);
        if (wq.size() == 2) begin
            check("init w0 addr", wq[0].addr, 0);
            check("init w0 d", wq[0].d, 0);
            check("init w1 addr", wq[1].addr, 1);
            check("init w1 d", wq[1].d, 0);
            check("init stable", int'(wq[0].stable && wq[1].stable), 1);
        end
        check("ldacn low", dac_ldacn, 0);

        // ch1 inc x3 by 8, with latency of the first write
        wq.delete();
        pulse(1, 1, 0, 8, n);
        @(negedge clk);
        check("led before update", led_out, 0);
        pulse(1, 1, 0, 8, s);
        @(negedge clk);
        check("led after first inc", led_out, 8);
        pulse(1, 1, 0, 8, s);
        mv[1] = 24;
        wait_idle("inc3");
        check("inc3 writes", wq.size(), 2);
        if (wq.size() == 2) begin
            check("inc3 w0 d", wq[0].d, 8);
            check("inc3 wrn fall", wq[0].fall, n + 2 + TS);
            check("inc3 wr_done", wq[0].done, n + 1 + TS + TW + TH);
            check("inc3 last addr", wq[1].addr, 1);
            check("inc3 last d", wq[1].d, 8'h18);
        end

        // Edit ch0 while its write is in flight
        wq.delete();
        pulse(0, 1, 0, 5, n);
        wait_wrn_low("mid");
        pulse(0, 1, 0, 1, n);
        mv[0] = 6;
        wait_idle("mid");
        check("mid writes", wq.size(), 2);
        if (wq.size() == 2) begin
            check("mid w0 d", wq[0].d, 5);
            check("mid w1 addr", wq[1].addr, 0);
            check("mid w1 d", wq[1].d, 6);
            check("mid stable", int'(wq[0].stable && wq[1].stable), 1);
        end

        // inc&dec together, and out-of-range channel
        wq.delete();
        pulse(1, 1, 1, 3, n);
        @(negedge clk); @(negedge clk);
        check("incdec led", led_out, mv[1]);
        wait_idle("incdec");
        check("incdec writes", wq.size(), 0);
        pulse(3, 1, 0, 1, n);
        @(negedge clk); @(negedge clk);
        check("ch3 led", led_out, 0);
        wait_idle("ch3");
        check("ch3 writes", wq.size(), 0);

        // Reset during WRITE
        pulse(0, 1, 0, 1, n);
        wait_wrn_low("rstmid");
        rst = 1'b1;
        @(negedge clk);
        check("rstmid wrn", dac_wrn, 1);
        check("rstmid csn", dac_csn, 1);
        check("rstmid busy", busy, 0);
        check("rstmid d", dac_d, 0);
        rst = 1'b0;
        mv[0] = 0; mv[1] = 0;
        wq.delete();
        wait_idle("reinit");
        check("reinit writes", wq.size(), 2);
        if (wq.size() == 2) begin
            check("reinit w0", wq[0].addr * 256 + wq[0].d, 0);
            check("reinit w1", wq[1].addr * 256 + wq[1].d, 256);
        end

        // dec by 1 from 0
        wq.delete();
        pulse(1, 0, 1, 1, n);
        mv[1] = apply(mv[1], 0, 1);
        wait_idle("dec0");
`ifdef DAC_SAT_EN
        check("dec0 writes", wq.size(), 0);
`else
        check("dec0 writes", wq.size(), 1);
        if (wq.size() == 1) check("dec0 d", wq[0].d, 8'hFF);
`endif
        check("dec0 led", led_out, mv[1]);

        // Randomized edits against the reference
        wq.delete();
        lastw[0] = mv[0]; lastw[1] = mv[1];
        for (int k = 0; k < 40; k++) begin
            ch = $urandom_range(0, 3);
            i  = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            if (!i && !d) i = 1'b1;
            s  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
            pulse(ch, i, d, s, n);
            if (ch < NCH && (i ^ d)) mv[ch] = apply(mv[ch], i, s);
            @(negedge clk); @(negedge clk);
            check($sformatf("rand led k=%0d", k), led_out, (ch < NCH) ? mv[ch] : 0);
            gap = $urandom_range(0, 12);
            repeat (gap) @(posedge clk);
        end
        wait_idle("rand");
        foreach (wq[q]) begin
            if (wq[q].addr < NCH) lastw[wq[q].addr] = wq[q].d;
            check($sformatf("rand stable q=%0d", q), int'(wq[q].stable), 1);
        end
        check("rand final ch0", lastw[0], mv[0]);
        check("rand final ch1", lastw[1], mv[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
